// File: rtl/cci_mpf_shim_vtp_svc_if.sv
// VTP translation service link: lookupReq = {pageVA[35:0], tag[3:0]},
// lookupRsp = {pagePA[25:0], tag[3:0], isBigPage}.
interface cci_mpf_shim_vtp_svc_if;
  logic        lookupEn;
  logic [39:0] lookupReq;
  logic        lookupRdy;
  logic        lookupRspValid;
  logic [30:0] lookupRsp;

  modport server (input lookupEn, lookupReq, output lookupRdy, lookupRspValid, lookupRsp);
  modport client (output lookupEn, lookupReq, input lookupRdy, lookupRspValid, lookupRsp);
endinterface

// File: rtl/cci_mpf_svc_vtp_arb.sv
// Shares one VTP translation service among several pipeline shims: per-client
// request FIFOs, round-robin issue, and a 16-entry server tag pool for remapping responses.
module cci_mpf_svc_vtp_arb #(
  parameter int N_VTP_CLIENTS  = 2,
  parameter int REQ_FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  cci_mpf_shim_vtp_svc_if.server clients [N_VTP_CLIENTS],
  cci_mpf_shim_vtp_svc_if.client to_svc,
  output logic                   tagError
);
  localparam int CW = $clog2(N_VTP_CLIENTS);
  localparam int PW = $clog2(REQ_FIFO_DEPTH);
  localparam int NT = 16;

  logic [39:0]              r_fifo [N_VTP_CLIENTS][REQ_FIFO_DEPTH];
  logic [PW-1:0]            r_rd_ptr [N_VTP_CLIENTS];
  logic [PW-1:0]            r_wr_ptr [N_VTP_CLIENTS];
  logic [PW:0]              r_count [N_VTP_CLIENTS];
  logic [CW-1:0]            r_last_grant;
  logic [NT-1:0]            r_free;
  logic [CW-1:0]            r_map_client [NT];
  logic [3:0]               r_map_tag [NT];
  logic [N_VTP_CLIENTS-1:0] r_rsp_vld;
  logic [30:0]              r_rsp;
  logic                     r_tag_error;

  logic [N_VTP_CLIENTS-1:0] w_rdy;
  logic [N_VTP_CLIENTS-1:0] w_push;
  logic [N_VTP_CLIENTS-1:0] w_pop;
  logic [N_VTP_CLIENTS-1:0] w_head_vld;
  logic [39:0]              w_push_req [N_VTP_CLIENTS];
  logic [CW-1:0]            w_grant;
  logic                     w_grant_any;
  logic [3:0]               w_alloc_tag;
  logic                     w_tag_any;
  logic                     w_issue;
  logic [39:0]              w_head;
  logic [3:0]               w_rsp_tag;
  logic                     w_rsp_hit;

  for (genvar gi = 0; gi < N_VTP_CLIENTS; gi++) begin : g_client
    // Ready depends only on the registered fill level, never on the server side.
    assign w_rdy[gi]       = !reset && (r_count[gi] < (PW+1)'(REQ_FIFO_DEPTH));
    assign w_push[gi]      = clients[gi].lookupEn && w_rdy[gi];
    assign w_push_req[gi]  = clients[gi].lookupReq;
    assign w_head_vld[gi]  = (r_count[gi] != '0);
    assign w_pop[gi]       = w_issue && (w_grant == CW'(gi));
    assign clients[gi].lookupRdy      = w_rdy[gi];
    assign clients[gi].lookupRspValid = r_rsp_vld[gi] && !reset;
    assign clients[gi].lookupRsp      = r_rsp;
  end

  // Round-robin: the client right after the last grant has highest priority.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant     = '0;
    w_grant_any = 1'b0;
    for (int k = N_VTP_CLIENTS; k >= 1; k--) begin
      idx = int'(r_last_grant) + k;
      if (idx >= N_VTP_CLIENTS) idx = idx - N_VTP_CLIENTS;
      if (w_head_vld[CW'(idx)]) begin
        w_grant     = CW'(idx);
        w_grant_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_alloc_tag = '0;
    for (int t = NT - 1; t >= 0; t--) begin
      if (r_free[t]) w_alloc_tag = 4'(t);
    end
  end

  assign w_tag_any = |r_free;
  assign w_issue   = !reset && w_grant_any && w_tag_any && to_svc.lookupRdy;
  assign w_head    = r_fifo[w_grant][r_rd_ptr[w_grant]];
  assign w_rsp_tag = to_svc.lookupRsp[4:1];
  assign w_rsp_hit = to_svc.lookupRspValid && !r_free[w_rsp_tag];

  assign to_svc.lookupEn  = w_issue;
  assign to_svc.lookupReq = {w_head[39:4], w_alloc_tag};
  assign tagError         = r_tag_error && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_VTP_CLIENTS; i++) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      r_last_grant <= CW'(N_VTP_CLIENTS - 1);
      r_free       <= '1;
      r_rsp_vld    <= '0;
      r_rsp        <= '0;
      r_tag_error  <= 1'b0;
    end else begin
      for (int i = 0; i < N_VTP_CLIENTS; i++) begin
        if (w_push[i]) begin
          r_fifo[i][r_wr_ptr[i]] <= w_push_req[i];
          r_wr_ptr[i]            <= r_wr_ptr[i] + PW'(1);
        end
        if (w_pop[i]) r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
        if (w_push[i] && !w_pop[i]) r_count[i] <= r_count[i] + (PW+1)'(1);
        else if (!w_push[i] && w_pop[i]) r_count[i] <= r_count[i] - (PW+1)'(1);
      end

      if (w_issue) begin
        r_last_grant              <= w_grant;
        r_map_client[w_alloc_tag] <= w_grant;
        r_map_tag[w_alloc_tag]    <= w_head[3:0];
        r_free[w_alloc_tag]       <= 1'b0;
      end

      // The freed tag only reappears in r_free next cycle, so it cannot be reissued now.
      r_rsp_vld <= '0;
      if (w_rsp_hit) begin
        r_rsp_vld[r_map_client[w_rsp_tag]] <= 1'b1;
        r_rsp <= {to_svc.lookupRsp[30:5], r_map_tag[w_rsp_tag], to_svc.lookupRsp[0]};
        r_free[w_rsp_tag] <= 1'b1;
      end else if (to_svc.lookupRspValid) begin
        r_tag_error <= 1'b1;
      end
    end
  end
endmodule

// File: doc/cci_mpf_svc_vtp_arb.md
CCI_MPF_SVC_VTP_ARB -- requirements
Module: cci_mpf_svc_vtp_arb

Interface
REQ-001 SHALL have parameter N_VTP_CLIENTS, default 2, meaning the number of VTP pipeline shims sharing one translation service (range 2..8).
REQ-002 SHALL have parameter REQ_FIFO_DEPTH, default 2, meaning the per-client request buffer depth (power of 2, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port clients[N_VTP_CLIENTS], a cci_mpf_shim_vtp_svc_if.server array: lookupEn 1, lookupReq 40 (pageVA 36 + tag 4), lookupRdy 1, lookupRspValid 1, lookupRsp 31 (pagePA 26 + tag 4 + isBigPage 1).
REQ-006 SHALL have port to_svc, a cci_mpf_shim_vtp_svc_if.client, with the same field widths as REQ-005.
REQ-007 SHALL have port tagError, output, 1 bit: sticky flag for a server response that carries an unallocated tag.

Function
REQ-008 SHALL give each client its own FIFO of REQ_FIFO_DEPTH entries, holding {pageVA, client tag}.
REQ-009 SHALL drive clients[i].lookupRdy = 1 when FIFO i count < REQ_FIFO_DEPTH, decoded from registered count only with no combinational path from to_svc.
REQ-010 SHALL treat client lookupEn as valid only when lookupRdy was high in the same cycle; lookupEn while full is a protocol violation, dropped, with no state change.
REQ-011 SHALL keep a 16-entry server tag pool (free bit vector) plus a 16-entry table mapping server tag -> {client index, client tag}.
REQ-012 SHALL issue when at least one FIFO head is valid, to_svc.lookupRdy=1 and at least one tag is free: assert to_svc.lookupEn the same cycle (combinational from registered state plus to_svc.lookupRdy).
REQ-013 SHALL allocate the lowest-numbered free tag, place it in to_svc.lookupReq.tag with pageVA unchanged, record the mapping, mark the tag busy, and pop the granted FIFO, all at that clock edge.
REQ-014 SHALL grant round-robin: search starts at client (lastGrant+1) mod N and wraps; lastGrant updates only on issue; at most one issue per cycle.
REQ-015 SHALL give minimum request latency of 1 cycle: client lookupEn at cycle t (FIFO empty) -> to_svc.lookupEn at t+1.
REQ-016 SHALL register a to_svc.lookupRspValid at cycle t and drive clients[k].lookupRspValid=1 at t+1, where k is the mapped client, with pagePA and isBigPage copied and tag restored to the client tag; all other clients see lookupRspValid=0.
REQ-017 SHALL provide no response back-pressure: clients must accept a response every cycle.
REQ-018 SHALL free the tag at the edge ending cycle t; it is allocatable from t+1. An issue and a response in the same cycle are both honoured, and a tag freed in cycle t is never reallocated in cycle t.
REQ-019 SHALL ignore a response whose tag is not busy: no client response is produced, the free vector is unchanged, and tagError is set to 1 until reset.
REQ-020 SHALL hold requests when all 16 tags are busy: FIFOs fill and lookupRdy deasserts per REQ-009, with no loss or reordering within a client.
REQ-021 SHALL preserve per-client FIFO issue order; responses may return out of order across tags.

Reset
REQ-022 SHALL, while reset=1, drive all lookupRdy, to_svc.lookupEn, clients[*].lookupRspValid and tagError to 0; FIFOs empty, all 16 tags free, lastGrant = N_VTP_CLIENTS-1 (client 0 wins first).
REQ-023 SHALL discard all outstanding requests and mappings on reset mid-operation; responses arriving at or after the first post-reset cycle for pre-reset tags set tagError per REQ-019.
REQ-024 SHALL assert lookupRdy=1 on every client in the first cycle after reset deasserts.

Verification
REQ-025 SHALL cover: client0 lookupEn with pageVA=0x123456789, tag=5, server ready -> next cycle to_svc.lookupEn=1, pageVA=0x123456789, tag=0; server response tag=0, PA=0x2ABCDEF -> next cycle client0 rsp tag=5, PA=0x2ABCDEF.
REQ-026 SHALL cover: clients 0 and 1 both request every cycle, server always ready -> grants alternate 0,1,0,1 and server tags 0,1,2,3.
REQ-027 SHALL cover: 16 issues with no responses -> to_svc.lookupEn stays 0 while FIFOs fill and lookupRdy=0 at count 2; a response for tag 7 -> the next issue uses tag 7.
REQ-028 SHALL cover: a response for tag 3 in the same cycle as an issue with only tag 3 busy-freeing -> the issue takes a different free tag and tag 3 is free the next cycle.
REQ-029 SHALL cover: a response with unallocated tag 9 -> no client lookupRspValid and tagError=1 until reset.
REQ-030 SHALL cover: reset asserted with 4 requests outstanding -> all outputs 0 during reset; lookupRdy=1 on all clients one cycle after release; first issue uses tag 0.
